// File: rtl/pkt_fifo_pkg.sv
// Shared widths, write-side state encoding and sizing helpers for the
// packet store FIFO. Optional drop counter: PKT_FIFO_DROP_CNT_EN.
package pkt_fifo_pkg;

  localparam int DATA_W  = 256;
  localparam int TUSER_W = 128;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + TUSER_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITING,
    DROPPING
  } wr_state_e;

  function automatic int entry_w(int d, int u);
    return d + d / 8 + u + 1;
  endfunction

endpackage

// File: rtl/pkt_store_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read.
// Contents are not reset; validity is tracked by the FIFO pointers.
module pkt_store_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_store_fifo.sv
// Store-and-forward AXI4-Stream packet queue with FWFT read port.
// Optional saturating drop counter port: PKT_FIFO_DROP_CNT_EN.
module pkt_store_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2           = 9,
  parameter int PKT_CNT_W            = 10
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    o_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  o_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   o_tuser,
  output logic                              o_tlast,
  output logic                              o_tvalid,
  output logic                              o_pkt_fifo_empty,
`ifdef PKT_FIFO_DROP_CNT_EN
  output logic [31:0]                       o_drop_cnt,
`endif
  input  logic                              i_pkt_fifo_rd_en
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int EW = entry_w(DW, UW);
  localparam int PW = DEPTH_LOG2 + 1;

  wr_state_e state, nxt;

  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, used;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [EW-1:0] wdata, rdata;
  logic full, beat, pop, pop_last;
  logic wr_en, commit, rollback;

  assign s_axis_tready = axis_resetn;
  assign beat = s_axis_tvalid & s_axis_tready;
  assign used = wr_ptr - rd_ptr;
  assign full = (used == {1'b1, {DEPTH_LOG2{1'b0}}});

  always_comb begin
    nxt      = state;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    if (beat) begin
      unique case (1'b1)
        (state == DROPPING): begin
          if (s_axis_tlast) begin
            nxt      = IDLE;
            rollback = 1'b1;
          end
        end
        (state != DROPPING) && full: begin
          // a tlast on a full FIFO ends the drop in the same beat
          if (s_axis_tlast) begin
            nxt      = IDLE;
            rollback = 1'b1;
          end else begin
            nxt = DROPPING;
          end
        end
        (state != DROPPING) && !full: begin
          wr_en  = 1'b1;
          commit = s_axis_tlast;
          nxt    = s_axis_tlast ? IDLE : WRITING;
        end
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= IDLE;
    else              state <= nxt;
  end

  assign pop      = i_pkt_fifo_rd_en & o_tvalid;
  assign pop_last = pop & rdata[EW-1];

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (wr_en)         wr_ptr <= wr_ptr + PW'(1);
      else if (rollback) wr_ptr <= wr_commit;
      if (commit) wr_commit <= wr_ptr + PW'(1);
      if (pop)    rd_ptr    <= rd_ptr + PW'(1);
      unique case ({commit, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign wdata = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  pkt_store_ram #(
    .W  (EW),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );

  assign o_tvalid         = (rd_ptr != wr_commit);
  assign o_tdata          = rdata[DW-1:0];
  assign o_tkeep          = rdata[DW+KW-1:DW];
  assign o_tuser          = rdata[DW+KW+UW-1:DW+KW];
  assign o_tlast          = o_tvalid & rdata[EW-1];
  assign o_pkt_fifo_empty = (pkt_cnt == '0);

`ifdef PKT_FIFO_DROP_CNT_EN
  logic [31:0] drop_cnt;
  logic drop_end;

  assign drop_end = beat & s_axis_tlast & ((state == DROPPING) | full);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn)
      drop_cnt <= '0;
    else if (drop_end && (drop_cnt != 32'hFFFF_FFFF))
      drop_cnt <= drop_cnt + 32'd1;
  end

  assign o_drop_cnt = drop_cnt;
`endif

endmodule

// File: tb/tb_pkt_store_fifo.sv
// Directed plus randomized bench for pkt_store_fifo against a
// queue-based packet model (8-entry instance to exercise overflow).
module tb_pkt_store_fifo;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int UW    = 32;
  localparam int L2    = 3;
  localparam int DEPTH = 2**L2;

  logic          axis_aclk;
  logic          axis_resetn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic [UW-1:0] o_tuser;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_pkt_fifo_empty;
  logic          i_pkt_fifo_rd_en;
`ifdef PKT_FIFO_DROP_CNT_EN
  logic [31:0]   o_drop_cnt;
`endif

  pkt_store_fifo #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .DEPTH_LOG2           (L2),
    .PKT_CNT_W            (4)
  ) dut (
    .axis_aclk        (axis_aclk),
    .axis_resetn      (axis_resetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .o_tdata          (o_tdata),
    .o_tkeep          (o_tkeep),
    .o_tuser          (o_tuser),
    .o_tlast          (o_tlast),
    .o_tvalid         (o_tvalid),
    .o_pkt_fifo_empty (o_pkt_fifo_empty),
`ifdef PKT_FIFO_DROP_CNT_EN
    .o_drop_cnt       (o_drop_cnt),
`endif
    .i_pkt_fifo_rd_en (i_pkt_fifo_rd_en)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t mq[$];
  beat_t pend[$];
  bit    mdrop;
  int    mpk;
  int    mdrops;
  int    checks;
  int    errors;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tready", s_axis_tready, 1'b1);
    chk("tvalid", o_tvalid, mq.size() > 0);
    chk("empty", o_pkt_fifo_empty, mpk == 0);
    if (mq.size() > 0) begin
      chk("tdata", o_tdata, mq[0].d);
      chk("tkeep", o_tkeep, mq[0].k);
      chk("tuser", o_tuser, mq[0].u);
      chk("tlast", o_tlast, mq[0].l);
    end
`ifdef PKT_FIFO_DROP_CNT_EN
    chk("drop_cnt", o_drop_cnt, mdrops);
`endif
  endtask

  // Packet-level model: committed beats, the packet being built, drop flag.
  task automatic model_clk();
    bit full = (mq.size() + pend.size()) == DEPTH;
    beat_t b;
    b = '{s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    if (i_pkt_fifo_rd_en && mq.size() > 0) begin
      if (mq[0].l) mpk--;
      void'(mq.pop_front());
    end
    if (s_axis_tvalid) begin
      if (mdrop) begin
        if (b.l) begin
          mdrop = 0;
          pend.delete();
          mdrops++;
        end
      end else if (full) begin
        if (b.l) begin
          pend.delete();
          mdrops++;
        end else begin
          mdrop = 1;
        end
      end else begin
        pend.push_back(b);
        if (b.l) begin
          foreach (pend[i]) mq.push_back(pend[i]);
          pend.delete();
          mpk++;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    mdrop  = 0;
    mpk    = 0;
    mdrops = 0;
  endtask

  task automatic step(bit v, bit l, bit rd, logic [UW-1:0] u);
    s_axis_tvalid    = v;
    s_axis_tlast     = l;
    s_axis_tdata     = {$urandom, $urandom};
    s_axis_tkeep     = KW'($urandom);
    s_axis_tuser     = u;
    i_pkt_fifo_rd_en = rd;
    #1;
    check_outputs();
    model_clk();
    @(posedge axis_aclk);
    @(negedge axis_aclk);
  endtask

  task automatic send(int n, bit rd);
    for (int i = 0; i < n; i++) step(1'b1, i == n - 1, rd, $urandom);
  endtask

  task automatic idle(int n, bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rd, '0);
  endtask

  task automatic reset_checks();
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_empty", o_pkt_fifo_empty, 1'b1);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_tlast", o_tlast, 1'b0);
  endtask

  initial begin
    int left;
    bit v;
    checks = 0;
    errors = 0;
    model_reset();
    axis_resetn      = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tkeep     = '0;
    s_axis_tuser     = '0;
    i_pkt_fifo_rd_en = 1'b0;
    repeat (2) @(negedge axis_aclk);
    reset_checks();
    axis_resetn = 1'b1;
    @(negedge axis_aclk);

    // single-beat packet, tuser 0x40 in [23:16]
    step(1'b1, 1'b1, 1'b0, 32'h0040_0000);
    chk("single_tuser", o_tuser[23:16], 8'h40);
    chk("single_tlast", o_tlast, 1'b1);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // 4-beat packet drained back to back
    send(4, 1'b0);
    idle(4, 1'b1);
    idle(1, 1'b0);

    // partial packet stays invisible until its tlast
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 1'b0, $urandom);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // overflow: 8-beat packet fills, next 3-beat packet dropped
    send(8, 1'b0);
    send(3, 1'b0);
    idle(10, 1'b1);
`ifdef PKT_FIFO_DROP_CNT_EN
    chk("drop_cnt_one", o_drop_cnt, 32'd1);
`endif
    send(8, 1'b0);
    idle(9, 1'b1);

    // commit of B coincides with last-word pop of A
    send(1, 1'b0);
    step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom);
    chk("cmt_pop_empty", o_pkt_fifo_empty, 1'b0);
    idle(3, 1'b1);

    // reset mid-packet with a committed packet also stored
    send(2, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    #2;
    axis_resetn = 1'b0;
    #1;
    reset_checks();
    model_reset();
    s_axis_tvalid = 1'b0;
    @(posedge axis_aclk);
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    idle(2, 1'b1);
    send(5, 1'b0);
    idle(6, 1'b1);

    // randomized traffic, low then high read pressure
    left = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v && left == 0) left = $urandom_range(1, 6);
      step(v, v && left == 1, $urandom_range(0, 3) < (c < 300 ? 1 : 3), $urandom);
      if (v) left--;
    end
    idle(20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
